shared_wf_accumulator: RTL and testbench
========================================

# shared_wf_accumulator

Resource-shared replacement for the per-channel complex weight multiply and adder chain in the hybrid fixed-point filter's lookback path. It sits directly downstream of the N complex recursion modules, on the same clkRecurse clock. On each start strobe it captures all N complex recursion outputs. It then time-multiplexes one complex multiplier over the channels, computing the real part of each channel's product with its complex weight W. It accumulates the N products and emits one lookback partial result per start, replacing N parallel multipliers and the N-1 adders that follow them.

## Interface
- N, 4: number of recursion channels.
- OSR2, 6: clkRecurse cycles per downsampled output; must be at least N+2.
- n_int, 9: integer bits of the fixed-point format.
- n_mant, 15: fractional bits of the fixed-point format. Word width W = n_int+n_mant+1, signed two's complement.

- clkRecurse  input  1  recursion-rate clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle capture strobe, asserted where osrCount2 == 0.
- inR  input  N*W  packed real recursion outputs; channel k is at [k*W +: W].
- inI  input  N*W  packed imaginary recursion outputs, same packing as inR.
- wR  input  N*W  packed real weights; quasi-static.
- wI  input  N*W  packed imaginary weights; quasi-static.
- out  output  W  accumulated real result.
- out_valid  output  1  one-cycle pulse when out is updated.
- busy  output  1  high while a sequence is in progress.
- overrun  output  1  sticky flag for a start dropped while busy.

## Operation
- States:
  - IDLE: waiting for start.
  - MUL: products issued for channels 0..N-1.
  - DRAIN: the last product is accumulated.
- IDLE, start=1:
  - hold registers latch inR/inI.
  - idx is set to 0.
  - busy is set to 1.
  - state goes to MUL.
- MUL, each edge:
  - prod <= (holdR[idx]*wR[idx] - holdI[idx]*wI[idx]) >>> n_mant, computed full-width at 2W bits with an arithmetic shift (floor).
  - acc <= (first MUL edge ? 0 : acc + prod).
  - idx increments.
  - After the idx = N-1 product, state goes to DRAIN.
- DRAIN, one edge:
  - out <= result of acc + prod.
  - out_valid is set to 1.
  - busy is set to 0.
  - state goes to IDLE.
- acc width is W+clog2(N). The final sum is reduced to W bits per the Configuration section.
- start while busy=1: ignored, overrun is set to 1 and stays set until reset, and the running sequence is unaffected.
- start is sampled only in IDLE; the minimum start spacing is N+2 edges.
- wR/wI are sampled combinationally during MUL and must be stable from start until out_valid.
- rst=0 at any edge, including mid-sequence:
  - state goes to IDLE.
  - out=0, out_valid=0, busy=0, overrun=0.
  - idx, acc, prod and the hold registers are cleared.
  - An aborted sequence never produces out_valid.

## Timing
- Start sampled at edge 0.
- Products are issued at edges 1..N.
- The last accumulation and the out/out_valid update happen at edge N+1. Latency is N+1 clkRecurse cycles.
- out_valid is high for exactly one cycle. out holds its value until the next out_valid.
- busy is high from edge 0 through edge N+1, deasserting at the same edge out_valid rises.
- Reset values of all outputs are 0.

## Configuration
- SHARED_WF_SAT_EN defined: the final sum saturates to [-2^(W-1), 2^(W-1)-1].
- SHARED_WF_SAT_EN undefined: the final sum keeps its low W bits (two's-complement wrap).

## Test plan
All scenarios use N=4, n_int=9, n_mant=15, W=25, 1.0 = 32768.
- All inR=32768, inI=0, wR=16384, wI=0; start at cycle 0 → out_valid high only at edge 5, out=65536 (2.0), busy high for edges 0..5.
- Channel 0 inI=32768 and wI=32768, all other inputs and weights 0 → out=-32768 (-1.0).
- All inR=8355840 (255.0), wR=32768 → out=16777215 with SHARED_WF_SAT_EN, out=-131072 (wrap, -4.0) without it.
- Start at cycle 0, again at cycle 2, and again at cycle 6:
  - The cycle-2 start is dropped and overrun=1.
  - The cycle-0 sequence gives its correct value at edge 5.
  - The cycle-6 start is accepted, with out_valid at edge 11; overrun stays 1.
- rst=0 at cycle 3 of a sequence, released at cycle 4, new start at cycle 5:
  - No out_valid appears at edge 5.
  - All outputs read 0 during reset.
  - The new result arrives at edge 10.
- Periodic start every OSR2=6 cycles for 10 periods with random inputs: each out matches the reference model, and overrun stays 0.

Source files
------------

// File: rtl/shared_wf_accumulator.sv
// shared_wf_accumulator: one shared complex multiplier walks the N captured
// recursion outputs, forming Re{x[k]*W[k]} per channel and summing them into
// one lookback partial result per start strobe.
// Build option: define SHARED_WF_SAT_EN to saturate the final sum to W bits;
// without it the final sum wraps (keeps its low W bits).
module shared_wf_accumulator #(
   parameter int unsigned N      = 4,
   parameter int unsigned OSR2   = 6,
   parameter int unsigned n_int  = 9,
   parameter int unsigned n_mant = 15,
   localparam int unsigned W     = n_int + n_mant + 1
) (
   input  logic           clkRecurse,
   input  logic           rst,
   input  logic           start,
   input  logic [N*W-1:0] inR,
   input  logic [N*W-1:0] inI,
   input  logic [N*W-1:0] wR,
   input  logic [N*W-1:0] wI,
   output logic [W-1:0]   out,
   output logic           out_valid,
   output logic           busy,
   output logic           overrun
);

   localparam int unsigned AW = W + $clog2(N);
   localparam int unsigned PW = 2 * W;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   // A sequence needs N+2 edges; an output period shorter than that never starts.
   localparam logic SPACING_OK = (OSR2 >= N + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state;
   logic [IW-1:0]        idx;
   logic signed [W-1:0]  hold_r [N];
   logic signed [W-1:0]  hold_i [N];
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] prod;

   logic signed [W-1:0]  w_r [N];
   logic signed [W-1:0]  w_i [N];
   logic signed [W-1:0]  cur_hr;
   logic signed [W-1:0]  cur_hi;
   logic signed [W-1:0]  cur_wr;
   logic signed [W-1:0]  cur_wi;
   logic signed [PW-1:0] prod_full;
   logic signed [AW-1:0] prod_next;
   logic [W-1:0]         sum_out;

   // Unpack the quasi-static weights into per-channel words.
   always_comb begin
      for (int unsigned k = 0; k < N; k++) begin
         w_r[k] = wR[k*W +: W];
         w_i[k] = wI[k*W +: W];
      end
   end

   // Shared multiplier: real part of hold[idx]*W[idx] at 2W bits, floor-scaled.
   always_comb begin
      cur_hr    = hold_r[idx];
      cur_hi    = hold_i[idx];
      cur_wr    = w_r[idx];
      cur_wi    = w_i[idx];
      prod_full = PW'(cur_hr) * PW'(cur_wr) - PW'(cur_hi) * PW'(cur_wi);
      prod_next = AW'(prod_full >>> n_mant);
   end

`ifdef SHARED_WF_SAT_EN
   logic signed [AW-1:0] sum;

   // Final sum clamped to the W-bit signed range.
   always_comb begin
      sum = acc + prod;
      if (sum[AW-1:W-1] == {(AW-W+1){sum[AW-1]}}) begin
         sum_out = sum[W-1:0];
      end else if (sum[AW-1]) begin
         sum_out = {1'b1, {(W-1){1'b0}}};
      end else begin
         sum_out = {1'b0, {(W-1){1'b1}}};
      end
   end
`else
   // Final sum wrapped to its low W bits.
   always_comb begin
      sum_out = W'(acc) + W'(prod);
   end
`endif

   // Sequencer, capture, accumulation and registered outputs.
   always_ff @(posedge clkRecurse) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         prod      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         for (int unsigned k = 0; k < N; k++) begin
            hold_r[k] <= '0;
            hold_i[k] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (start && busy) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start && SPACING_OK) begin
                  for (int unsigned k = 0; k < N; k++) begin
                     hold_r[k] <= inR[k*W +: W];
                     hold_i[k] <= inI[k*W +: W];
                  end
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               prod <= prod_next;
               acc  <= (idx == '0) ? '0 : acc + prod;
               if (idx == IW'(N - 1)) begin
                  state <= DRAIN;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DRAIN: begin
               out       <= sum_out;
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shared_wf_accumulator.sv
// tb_shared_wf_accumulator: directed vector table plus hand-written
// overrun, mid-sequence reset and periodic random sequences.
module tb_shared_wf_accumulator;

   localparam int unsigned N = 4;
   localparam int unsigned W = 25;

   logic           clkRecurse;
   logic           rst;
   logic           start;
   logic [N*W-1:0] inR;
   logic [N*W-1:0] inI;
   logic [N*W-1:0] wR;
   logic [N*W-1:0] wI;
   logic [W-1:0]   out;
   logic           out_valid;
   logic           busy;
   logic           overrun;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string  name;
      int     in_r [4];
      int     in_i [4];
      int     w_r  [4];
      int     w_i  [4];
      longint expv;
   } vec_t;

   vec_t vecs [4];

   shared_wf_accumulator #(
      .N(4), .OSR2(6), .n_int(9), .n_mant(15)
   ) dut (
      .clkRecurse(clkRecurse),
      .rst(rst),
      .start(start),
      .inR(inR),
      .inI(inI),
      .wR(wR),
      .wI(wI),
      .out(out),
      .out_valid(out_valid),
      .busy(busy),
      .overrun(overrun)
   );

   initial clkRecurse = 1'b0;
   always #5 clkRecurse = ~clkRecurse;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input longint act, input longint expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clkRecurse);
      #1;
   endtask

   function automatic logic [N*W-1:0] pack(input int a [4]);
      logic [N*W-1:0] p;
      p = '0;
      for (int k = 0; k < 4; k++) p[k*W +: W] = W'(a[k]);
      return p;
   endfunction

   function automatic longint sx(input longint x, input int w);
      return (x <<< (64 - w)) >>> (64 - w);
   endfunction

   // Reference: exact per-channel real product, floor shift, 27-bit accumulate.
   function automatic longint model(input int r [4], input int i [4],
                                    input int wr [4], input int wi [4]);
      longint acc;
      longint p;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         p   = (longint'(r[k]) * longint'(wr[k]) - longint'(i[k]) * longint'(wi[k])) >>> 15;
         acc = sx(acc + sx(p, 27), 27);
      end
`ifdef SHARED_WF_SAT_EN
      if (acc > 64'sd16777215) acc = 64'sd16777215;
      if (acc < -64'sd16777216) acc = -64'sd16777216;
      return acc;
`else
      return sx(acc, 25);
`endif
   endfunction

   function automatic longint out_s();
      return longint'($signed(out));
   endfunction

   task automatic load(input vec_t v);
      inR = pack(v.in_r);
      inI = pack(v.in_i);
      wR  = pack(v.w_r);
      wI  = pack(v.w_i);
   endtask

   // One full sequence from a start strobe through the cycle after out_valid.
   task automatic run_vec(input vec_t v);
      @(negedge clkRecurse);
      load(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({v.name, " busy@0"}, longint'(busy), 1);
      chk({v.name, " valid@0"}, longint'(out_valid), 0);
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk($sformatf("%s valid@%0d", v.name, e), longint'(out_valid), 0);
         chk($sformatf("%s busy@%0d", v.name, e), longint'(busy), 1);
      end
      tick();
      chk({v.name, " valid@5"}, longint'(out_valid), 1);
      chk({v.name, " busy@5"}, longint'(busy), 0);
      chk({v.name, " out@5"}, out_s(), v.expv);
      tick();
      chk({v.name, " valid@6"}, longint'(out_valid), 0);
      chk({v.name, " out hold"}, out_s(), v.expv);
   endtask

   initial begin
      vec_t   rv;
      longint sat_exp;

`ifdef SHARED_WF_SAT_EN
      sat_exp = 16777215;
`else
      sat_exp = -131072;
`endif
      vecs[0].name = "unit";
      vecs[0].in_r = '{32768, 32768, 32768, 32768};
      vecs[0].in_i = '{0, 0, 0, 0};
      vecs[0].w_r  = '{16384, 16384, 16384, 16384};
      vecs[0].w_i  = '{0, 0, 0, 0};
      vecs[0].expv = 65536;
      vecs[1].name = "imag";
      vecs[1].in_r = '{0, 0, 0, 0};
      vecs[1].in_i = '{32768, 0, 0, 0};
      vecs[1].w_r  = '{0, 0, 0, 0};
      vecs[1].w_i  = '{32768, 0, 0, 0};
      vecs[1].expv = -32768;
      vecs[2].name = "big";
      vecs[2].in_r = '{8355840, 8355840, 8355840, 8355840};
      vecs[2].in_i = '{0, 0, 0, 0};
      vecs[2].w_r  = '{32768, 32768, 32768, 32768};
      vecs[2].w_i  = '{0, 0, 0, 0};
      vecs[2].expv = sat_exp;
      // -1.0 + (1.0 - 1.0) - 1.5 + floor(-1/32768) = -81921 counts
      vecs[3].name = "mixed";
      vecs[3].in_r = '{32768, 65536, -16384, -1};
      vecs[3].in_i = '{0, 16384, 0, 0};
      vecs[3].w_r  = '{-32768, 16384, 98304, 1};
      vecs[3].w_i  = '{0, 65536, 0, 0};
      vecs[3].expv = -81921;

      rst   = 1'b0;
      start = 1'b0;
      inR   = '0;
      inI   = '0;
      wR    = '0;
      wI    = '0;
      tick();
      tick();
      chk("rst out", out_s(), 0);
      chk("rst valid", longint'(out_valid), 0);
      chk("rst busy", longint'(busy), 0);
      chk("rst overrun", longint'(overrun), 0);
      @(negedge clkRecurse);
      rst = 1'b1;
      tick();

      for (int t = 0; t < 4; t++) run_vec(vecs[t]);
      chk("no overrun after table", longint'(overrun), 0);

      // Overrun: starts at cycles 0, 2 and 6.
      @(negedge clkRecurse);
      load(vecs[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      @(negedge clkRecurse);
      inR   = pack(vecs[2].in_r);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ovr set@2", longint'(overrun), 1);
      chk("ovr busy@2", longint'(busy), 1);
      tick();
      tick();
      chk("ovr valid@4", longint'(out_valid), 0);
      tick();
      chk("ovr valid@5", longint'(out_valid), 1);
      chk("ovr out@5", out_s(), 65536);
      @(negedge clkRecurse);
      load(vecs[1]);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ovr busy@6", longint'(busy), 1);
      for (int e = 7; e <= 10; e++) begin
         tick();
         chk($sformatf("ovr valid@%0d", e), longint'(out_valid), 0);
      end
      tick();
      chk("ovr valid@11", longint'(out_valid), 1);
      chk("ovr out@11", out_s(), -32768);
      chk("ovr sticky", longint'(overrun), 1);

      // Reset at cycle 3 of a running sequence, restart at cycle 5.
      @(negedge clkRecurse);
      load(vecs[3]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(negedge clkRecurse);
      rst = 1'b0;
      tick();
      chk("mrst out", out_s(), 0);
      chk("mrst valid", longint'(out_valid), 0);
      chk("mrst busy", longint'(busy), 0);
      chk("mrst overrun", longint'(overrun), 0);
      @(negedge clkRecurse);
      rst = 1'b1;
      tick();
      @(negedge clkRecurse);
      load(vecs[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("mrst valid@5", longint'(out_valid), 0);
      chk("mrst busy@5", longint'(busy), 1);
      for (int e = 6; e <= 9; e++) begin
         tick();
         chk($sformatf("mrst valid@%0d", e), longint'(out_valid), 0);
      end
      tick();
      chk("mrst valid@10", longint'(out_valid), 1);
      chk("mrst out@10", out_s(), 65536);

      // Periodic starts every 6 cycles with random data.
      for (int p = 0; p < 10; p++) begin
         rv.name = "rand";
         for (int k = 0; k < 4; k++) begin
            rv.in_r[k] = int'($urandom_range(0, 2097151)) - 1048576;
            rv.in_i[k] = int'($urandom_range(0, 2097151)) - 1048576;
            rv.w_r[k]  = int'($urandom_range(0, 131071)) - 65536;
            rv.w_i[k]  = int'($urandom_range(0, 131071)) - 65536;
         end
         rv.expv = model(rv.in_r, rv.in_i, rv.w_r, rv.w_i);
         @(negedge clkRecurse);
         load(rv);
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int e = 1; e <= 4; e++) tick();
         tick();
         chk($sformatf("per%0d valid", p), longint'(out_valid), 1);
         chk($sformatf("per%0d out", p), out_s(), rv.expv);
      end
      chk("per overrun", longint'(overrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
